// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a shared memory port: round-robin or fixed priority,
// back-to-back grants on completion, and a per-access timeout.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT    = 15,
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   input  logic mem_ready,
   output logic gnt0,
   output logic gnt1,
   output logic sel,
   output logic mem_start,
   output logic done0,
   output logic done1,
   output logic timeout_err
);

   localparam int unsigned CW = 8;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t        state, state_d;
   logic [CW-1:0] wcnt, wcnt_d;
   logic          last, last_d;
   logic          gnt0_d, gnt1_d, sel_d, start_d, done0_d, done1_d, to_d;
   logic          arb_en, win, any_req, timeout_hit;

   assign any_req     = req0 | req1;
   assign timeout_hit = (wcnt == CW'(TIMEOUT - 1));

   // Winner of the current arbitration; a single request always wins.
   always_comb begin
      win = req1;
      if (req0 && req1) begin
         win = (FIXED_PRIO != 0) ? 1'b1 : ~last;
      end
   end

   // Next-state and registered-output values.
   always_comb begin
      state_d = state;
      wcnt_d  = wcnt;
      last_d  = last;
      gnt0_d  = gnt0;
      gnt1_d  = gnt1;
      sel_d   = sel;
      start_d = 1'b0;
      done0_d = 1'b0;
      done1_d = 1'b0;
      to_d    = 1'b0;
      arb_en  = 1'b0;

      case (state)
         IDLE: arb_en = 1'b1;
         BUSY: begin
            if (mem_ready) begin
               // Completion beats a coincident timeout; sel still names the owner.
               done0_d = ~sel;
               done1_d = sel;
               gnt0_d  = 1'b0;
               gnt1_d  = 1'b0;
               state_d = IDLE;
               arb_en  = 1'b1;
            end else if (timeout_hit) begin
               to_d    = 1'b1;
               gnt0_d  = 1'b0;
               gnt1_d  = 1'b0;
               wcnt_d  = '0;
               state_d = IDLE;
            end else begin
               wcnt_d = wcnt + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (arb_en && any_req) begin
         state_d = BUSY;
         gnt0_d  = ~win;
         gnt1_d  = win;
         sel_d   = win;
         last_d  = win;
         start_d = 1'b1;
         wcnt_d  = '0;
      end
   end

   // State, pointer, counter and output flops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         wcnt        <= '0;
         last        <= 1'b1;
         gnt0        <= 1'b0;
         gnt1        <= 1'b0;
         sel         <= 1'b0;
         mem_start   <= 1'b0;
         done0       <= 1'b0;
         done1       <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_d;
         wcnt        <= wcnt_d;
         last        <= last_d;
         gnt0        <= gnt0_d;
         gnt1        <= gnt1_d;
         sel         <= sel_d;
         mem_start   <= start_d;
         done0       <= done0_d;
         done1       <= done1_d;
         timeout_err <= to_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin (TIMEOUT=3) and a fixed-priority (TIMEOUT=5)
// instance share directed stimulus; a transaction-level model is compared every cycle.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic req0 = 1'b0, req1 = 1'b0, mem_ready = 1'b0;
   logic [1:0] gnt0, gnt1, sel, mem_start, done0, done1, timeout_err;

   int total = 0;
   int passed = 0;

   // Model state per instance: 0 = round-robin, 1 = fixed priority.
   bit m_busy[2];
   int m_owner[2];
   int m_last[2];
   int m_waits[2];
   bit e_g0[2], e_g1[2], e_sel[2], e_start[2], e_d0[2], e_d1[2], e_to[2];

   always #5 clk = ~clk;

   mem_port_arbiter #(.TIMEOUT(3), .FIXED_PRIO(0)) dut_rr (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .mem_ready(mem_ready),
      .gnt0(gnt0[0]), .gnt1(gnt1[0]), .sel(sel[0]), .mem_start(mem_start[0]),
      .done0(done0[0]), .done1(done1[0]), .timeout_err(timeout_err[0]));

   mem_port_arbiter #(.TIMEOUT(5), .FIXED_PRIO(1)) dut_fp (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .mem_ready(mem_ready),
      .gnt0(gnt0[1]), .gnt1(gnt1[1]), .sel(sel[1]), .mem_start(mem_start[1]),
      .done0(done0[1]), .done1(done1[1]), .timeout_err(timeout_err[1]));

   task automatic chk(input string nm, input logic act, input logic exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0b, expected %0b", nm, act, exp);
   endtask

   task automatic model_reset(input int i);
      m_busy[i] = 0; m_owner[i] = 0; m_last[i] = 1; m_waits[i] = 0;
      e_g0[i] = 0; e_g1[i] = 0; e_sel[i] = 0;
      e_start[i] = 0; e_d0[i] = 0; e_d1[i] = 0; e_to[i] = 0;
   endtask

   // One clock of the access-level behaviour: finish/abort the current access, then maybe grant.
   task automatic model_step(input int i);
      int  tmo;
      bit  may_grant;
      tmo = (i == 0) ? 3 : 5;
      e_start[i] = 0; e_d0[i] = 0; e_d1[i] = 0; e_to[i] = 0;
      may_grant = !m_busy[i];
      if (m_busy[i]) begin
         if (mem_ready) begin
            if (m_owner[i] == 0) e_d0[i] = 1; else e_d1[i] = 1;
            m_busy[i] = 0;
            may_grant = 1;
         end else begin
            m_waits[i]++;
            if (m_waits[i] >= tmo) begin
               e_to[i] = 1;
               m_busy[i] = 0;
            end
         end
      end
      if (may_grant && (req0 || req1)) begin
         if (req0 && req1) m_owner[i] = (i == 1) ? 1 : 1 - m_last[i];
         else m_owner[i] = req1 ? 1 : 0;
         m_last[i] = m_owner[i];
         m_busy[i] = 1;
         m_waits[i] = 0;
         e_start[i] = 1;
      end
      e_g0[i] = m_busy[i] && (m_owner[i] == 0);
      e_g1[i] = m_busy[i] && (m_owner[i] == 1);
      if (m_busy[i]) e_sel[i] = (m_owner[i] == 1);
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         model_reset(0);
         model_reset(1);
      end else begin
         model_step(0);
         model_step(1);
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("i%0d gnt0", i), gnt0[i], e_g0[i]);
         chk($sformatf("i%0d gnt1", i), gnt1[i], e_g1[i]);
         chk($sformatf("i%0d sel", i), sel[i], e_sel[i]);
         chk($sformatf("i%0d mem_start", i), mem_start[i], e_start[i]);
         chk($sformatf("i%0d done0", i), done0[i], e_d0[i]);
         chk($sformatf("i%0d done1", i), done1[i], e_d1[i]);
         chk($sformatf("i%0d timeout_err", i), timeout_err[i], e_to[i]);
         chk($sformatf("i%0d mutex", i), gnt0[i] & gnt1[i], 1'b0);
      end
   end

   task automatic cyc(input logic r0, input logic r1, input logic mr);
      req0 = r0; req1 = r1; mem_ready = mr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset gnt0", gnt0[0], 1'b0);
      chk("reset sel", sel[0], 1'b0);
      @(negedge clk);
      rst = 1'b1;

      // Tie right after reset: requester 0 wins the first round-robin tie.
      cyc(1, 1, 0);
      chk("tie gnt0", gnt0[0], 1'b1);
      chk("tie start", mem_start[0], 1'b1);
      chk("tie sel", sel[0], 1'b0);
      chk("fp tie gnt1", gnt1[1], 1'b1);
      cyc(1, 1, 0);
      cyc(1, 1, 0);
      chk("c3 gnt0", gnt0[0], 1'b1);
      chk("c3 start", mem_start[0], 1'b0);
      cyc(1, 1, 1);
      chk("c4 done0", done0[0], 1'b1);
      chk("c4 gnt1", gnt1[0], 1'b1);
      chk("c4 gnt0", gnt0[0], 1'b0);
      chk("c4 start", mem_start[0], 1'b1);
      chk("c4 sel", sel[0], 1'b1);
      chk("fp c4 done1", done1[1], 1'b1);
      chk("fp c4 gnt1", gnt1[1], 1'b1);

      // Fairness: alternation with no idle bubble.
      cyc(1, 1, 1);
      chk("rr alt gnt0", gnt0[0], 1'b1);
      chk("rr alt done1", done1[0], 1'b1);
      cyc(1, 1, 1);
      chk("rr alt gnt1", gnt1[0], 1'b1);
      chk("fp held gnt1", gnt1[1], 1'b1);
      cyc(1, 0, 1);
      chk("fp req0 only", gnt0[1], 1'b1);

      // Drain, then mem_ready while idle is ignored.
      cyc(0, 0, 1);
      chk("drain gnt0", gnt0[0], 1'b0);
      chk("drain done0", done0[0], 1'b1);
      cyc(0, 0, 1);
      chk("idle ready done0", done0[0], 1'b0);
      chk("idle ready done1", done1[0], 1'b0);

      // Timeout on a pulsed req1.
      cyc(0, 1, 0);
      chk("to grant", gnt1[0], 1'b1);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      chk("to pending gnt1", gnt1[0], 1'b1);
      chk("to pending err", timeout_err[0], 1'b0);
      cyc(0, 0, 0);
      chk("to err", timeout_err[0], 1'b1);
      chk("to gnt1 low", gnt1[0], 1'b0);
      chk("to no done1", done1[0], 1'b0);
      chk("to sel held", sel[0], 1'b1);
      // Aborted owner 1 counts as last owner, so requester 0 wins this tie.
      cyc(1, 1, 0);
      chk("after to err", timeout_err[0], 1'b0);
      chk("after to tie", gnt0[0], 1'b1);
      cyc(0, 0, 1);
      cyc(0, 0, 0);

      // Ready in the timeout cycle: completion wins.
      cyc(0, 1, 0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      cyc(0, 0, 1);
      chk("race done1", done1[0], 1'b1);
      chk("race no err", timeout_err[0], 1'b0);

      // Reset mid-access, with the owner's request already dropped.
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      chk("hold gnt0", gnt0[0], 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("async gnt0", gnt0[0], 1'b0);
      chk("async fp gnt0", gnt0[1], 1'b0);
      chk("async sel", sel[0], 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst no done0", done0[0], 1'b0);
      chk("rst no err", timeout_err[0], 1'b0);
      @(negedge clk);
      rst = 1'b1;
      cyc(1, 1, 0);
      chk("post rst tie", gnt0[0], 1'b1);
      chk("post rst done0", done0[0], 1'b0);
      cyc(1, 1, 1);
      cyc(0, 0, 1);
      cyc(0, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
